// File: rtl/bus_gate_arbiter.sv
// Round-robin bus arbiter for the four CPU gate sources (PC, MDR, ALU, MARMUX).
// Registered one-hot grant, one dead cycle between owners, bounded hold under contention.
module bus_gate_arbiter #(
  parameter int N        = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [3:0]   Req,
  input  logic [N-1:0] Src0_In,
  input  logic [N-1:0] Src1_In,
  input  logic [N-1:0] Src2_In,
  input  logic [N-1:0] Src3_In,
  output logic [3:0]   Gnt,
  output logic [1:0]   Owner,
  output logic         Bus_Valid,
  output logic [N-1:0] Bus_Out,
  output logic         Preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_d;
  logic [3:0] gnt_d;
  logic [1:0] owner_d;
  logic [7:0] hold_cnt, hold_d;
  logic [1:0] winner;
  logic       owner_req, others_req;

  // Scan starts just above the last owner, so the last owner is checked last.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    winner = Owner;
    found  = 1'b0;
    idx    = Owner;
    for (int i = 1; i <= 4; i++) begin
      idx = Owner + 2'(i);
      if (!found && Req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign owner_req  = Req[Owner];
  assign others_req = |(Req & ~(4'b0001 << Owner));

  // A releasing owner is never counted as preempted.
  assign Preempt = (state == GRANT) && owner_req && (hold_cnt == HOLD_LAST) && others_req;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_d = state;
    gnt_d   = Gnt;
    owner_d = Owner;
    hold_d  = hold_cnt;
    unique case (state)
      IDLE, TURN: begin
        hold_d = '0;
        if (|Req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          owner_d = winner;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        gnt_d = 4'b0001 << Owner;
        if (!owner_req || Preempt) begin
          state_d = TURN;
          gnt_d   = '0;
          hold_d  = '0;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_d = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Gnt      <= '0;
      Owner    <= 2'b11;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      Gnt      <= gnt_d;
      Owner    <= owner_d;
      hold_cnt <= hold_d;
    end
  end

  assign Bus_Valid = |Gnt;

  always_comb begin
    unique case (Gnt)
      4'b0001: Bus_Out = Src0_In;
      4'b0010: Bus_Out = Src1_In;
      4'b0100: Bus_Out = Src2_In;
      4'b1000: Bus_Out = Src3_In;
      default: Bus_Out = '0;
    endcase
  end

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed bench for bus_gate_arbiter: round-robin order, turnaround, preemption and reset.
module tb_bus_gate_arbiter;

  localparam int N = 16;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic [3:0]   Req;
  logic [N-1:0] Src0_In, Src1_In, Src2_In, Src3_In;
  logic [3:0]   Gnt;
  logic [1:0]   Owner;
  logic         Bus_Valid;
  logic [N-1:0] Bus_Out;
  logic         Preempt;

  int n_checks = 0;
  int n_errors = 0;

  bus_gate_arbiter #(.N(N), .MAX_HOLD(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req),
    .Src0_In(Src0_In), .Src1_In(Src1_In), .Src2_In(Src2_In), .Src3_In(Src3_In),
    .Gnt(Gnt), .Owner(Owner), .Bus_Valid(Bus_Valid), .Bus_Out(Bus_Out), .Preempt(Preempt)
  );

  always #5 Clk = ~Clk;

  localparam logic [N-1:0] S0 = 16'hA5A5;
  localparam logic [N-1:0] S1 = 16'h1234;
  localparam logic [N-1:0] S2 = 16'hBEEF;
  localparam logic [N-1:0] S3 = 16'h0F0F;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    Req     = 4'b0000;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  function automatic logic [N-1:0] src_of(input int idx);
    case (idx)
      0:       return S0;
      1:       return S1;
      2:       return S2;
      default: return S3;
    endcase
  endfunction

  // Checks the full bus view for an owner holding the bus.
  task automatic check_owner(input string tag, input int idx);
    check({tag, "_gnt"},   Gnt, 32'(4'b0001 << idx));
    check({tag, "_owner"}, Owner, 32'(idx));
    check({tag, "_bus"},   Bus_Out, 32'(src_of(idx)));
    check({tag, "_valid"}, Bus_Valid, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},   Gnt, 0);
    check({tag, "_bus"},   Bus_Out, 0);
    check({tag, "_valid"}, Bus_Valid, 0);
    check({tag, "_pre"},   Preempt, 0);
  endtask

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    Src0_In = S0;
    Src1_In = S1;
    Src2_In = S2;
    Src3_In = S3;
    Req     = 4'b0000;

    // Reset values
    do_reset();
    check_idle("rst");
    check("rst_owner", Owner, 3);

    // Single PC request for three cycles, then release
    Req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_owner("pc", 0);
    end
    Req = 4'b0000;
    tick();
    check_idle("pc_turn");
    check("pc_turn_owner", Owner, 0);
    tick();
    check_idle("pc_idle");
    check("pc_idle_owner", Owner, 0);

    // Full contention: rotation 0,1,2,3,0 with 8-cycle holds and preemption
    do_reset();
    Req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      for (int k = 0; k < 8; k++) begin
        tick();
        check_owner($sformatf("rr%0d_%0d", o, k), order[o]);
        check($sformatf("rr%0d_%0d_pre", o, k), Preempt, (k == 7) ? 1 : 0);
      end
      if (o < 4) begin
        tick();
        check_idle($sformatf("rr%0d_turn", o));
      end
    end

    // Lone ALU requester keeps the bus and is never preempted
    do_reset();
    Req = 4'b0100;
    tick();
    for (int k = 0; k < 20; k++) begin
      check_owner($sformatf("alu%0d", k), 2);
      check($sformatf("alu%0d_pre", k), Preempt, 0);
      tick();
    end

    // MDR releases with MARMUX and PC pending: MARMUX wins
    do_reset();
    Req = 4'b0010;
    tick();
    check_owner("mdr", 1);
    Req = 4'b1011;
    tick();
    check_owner("mdr_hold", 1);
    Req = 4'b1001;
    tick();
    check_idle("mdr_turn");
    tick();
    check_owner("mar_win", 3);

    // Asynchronous reset in the middle of an MDR grant
    do_reset();
    Req = 4'b0010;
    tick();
    check_owner("pre_rst", 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_owner", Owner, 3);
    Req = 4'b0110;
    #1;
    Reset_n = 1'b1;
    tick();
    check_owner("post_rst", 1);

    // Release on the same cycle the hold limit is reached: no preempt
    do_reset();
    Req = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_owner($sformatf("rel%0d", k), 0);
    end
    Req = 4'b0010;
    #1;
    check("rel_pre", Preempt, 0);
    tick();
    check_idle("rel_turn");
    tick();
    check_owner("rel_next", 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
